drink_vend_ctrl: RTL and testbench
==================================

Name: drink_vend_ctrl

Overview:
Top-level sequencer for the drink vending machine. Accumulates half-unit and one-unit coins into a credit counter and starts a dispense when credit reaches the drink price. Pays out change one half-coin at a time, and refunds the full credit on cancel or inactivity timeout. It talks to the dispenser mechanism and the change hopper through req/ack handshakes.

Parameters:
PRICE_HALVES, 5, drink price in half-unit coins (5 = 2.5 units); legal range 1..(2^CREDIT_W - 3).
CREDIT_W, 4, width of the credit register, in half-units.
TIMEOUT_CYC, 1000, idle cycles in COLLECT before an automatic refund; must be >= 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
coin_valid  input  1  one-cycle pulse: a coin has been inserted.
coin_one  input  1  qualifies coin_valid: 1 = one unit (2 halves), 0 = half unit (1 half).
cancel  input  1  one-cycle pulse: customer requests a refund.
disp_ack  input  1  dispenser has completed the drink drop.
chg_ack  input  1  hopper has ejected one half-coin.
disp_req  output  1  dispense request, registered.
chg_req  output  1  change/refund request, registered.
coin_rej  output  1  one-cycle pulse: a coin was rejected (returned by the mechanism), registered.
busy  output  1  high in DISPENSE and CHANGE, registered.
credit  output  CREDIT_W  current credit in half-units, registered.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; disp_req, chg_req, coin_rej, busy = 0; credit = 0; timeout counter = 0. A reset in the middle of an operation drops all requests immediately and discards any credit.
- Coin value: v = coin_one ? 2 : 1. The next-state credit is cn = credit + (coin_valid ? v : 0), computed at CREDIT_W+1 bits. cn never exceeds PRICE_HALVES+1, so there is no overflow.
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- IDLE:
  - On coin_valid with cn >= PRICE_HALVES: go to DISPENSE and load credit = cn - PRICE_HALVES.
  - On coin_valid otherwise: go to COLLECT and load credit = cn.
  - cancel in IDLE is ignored.
- COLLECT:
  - If cn >= PRICE_HALVES: go to DISPENSE and load credit = cn - PRICE_HALVES. A cancel in the same cycle is ignored.
  - Else if cancel: go to CHANGE with credit = cn. A coin in the same cycle is included in the refund.
  - Else if the timeout counter reaches TIMEOUT_CYC-1 with no coin: go to CHANGE with credit unchanged.
  - The timeout counter clears on every accepted coin and on every state change.
- DISPENSE:
  - disp_req = 1 from the first cycle in this state and held until disp_ack is sampled high.
  - On disp_ack: disp_req = 0 in the next cycle. Go to CHANGE if credit > 0, else IDLE.
  - disp_ack sampled outside DISPENSE is ignored.
- CHANGE:
  - chg_req = 1 while credit > 0.
  - Each cycle with chg_req & chg_ack: credit decrements by 1.
  - The ack that brings credit to 0 sends the state to IDLE; chg_req = 0 in the next cycle.
  - Entry with credit = 0 cannot occur (DISPENSE and COLLECT guarantee credit > 0 on entry).
- Coins in DISPENSE or CHANGE are not credited. coin_rej pulses high for exactly 1 cycle, in the cycle after each such coin_valid. cancel in these states is ignored.
- busy = 1 whenever the state is DISPENSE or CHANGE. All outputs change only on a clk edge or on reset.
- Latency: disp_req rises 1 cycle after the qualifying coin_valid. chg_req rises 1 cycle after disp_ack, cancel, or timeout expiry.

Test Plan:
1. Five half coins (coin_one=0), spaced 3 cycles apart -> credit steps 1,2,3,4, then 0 with disp_req=1 one cycle after the 5th coin. disp_ack after 4 cycles -> disp_req=0, state IDLE, chg_req never asserted.
2. Three one-unit coins -> credit 2, 4, then DISPENSE with credit=1. disp_ack -> chg_req=1; a single chg_ack -> credit=0, chg_req=0, IDLE.
3. One + half (credit=3), then cancel -> chg_req=1 for exactly 3 chg_acks, credit 3->2->1->0, disp_req never asserted.
4. One coin (credit=2), then no activity for TIMEOUT_CYC cycles -> CHANGE entered, refund of 2 half-coins; with TIMEOUT_CYC=8, chg_req rises on the 9th cycle after the coin.
5. coin_valid during DISPENSE -> coin_rej=1 for 1 cycle, credit unchanged. Then pull reset low while disp_req=1 -> disp_req, busy, credit all 0 immediately.
6. Credit=4, then coin_valid (half) and cancel in the same cycle -> DISPENSE with credit=0, no refund. Credit=2, then half coin and cancel together -> CHANGE with credit=3.

Source files
------------

// File: rtl/drink_vend_if.sv
// Handshake and status bundle between the vending sequencer and its environment
// (coin acceptor, cancel button, dispenser and change hopper).
interface drink_vend_if #(
    parameter int CREDIT_W = 4
);
    logic                coin_valid;
    logic                coin_one;
    logic                cancel;
    logic                disp_ack;
    logic                chg_ack;
    logic                disp_req;
    logic                chg_req;
    logic                coin_rej;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin_valid, coin_one, cancel, disp_ack, chg_ack,
        input  disp_req, chg_req, coin_rej, busy, credit
    );

    modport slave (
        input  coin_valid, coin_one, cancel, disp_ack, chg_ack,
        output disp_req, chg_req, coin_rej, busy, credit
    );
endinterface

// File: rtl/drink_vend_ctrl.sv
// Drink vending sequencer: collects coins into a half-unit credit, requests a dispense
// at the price, then pays change or refunds one half-coin per hopper ack.
module drink_vend_ctrl #(
    parameter int PRICE_HALVES = 5,
    parameter int CREDIT_W     = 4,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic         clk,
    input  logic         reset,
    drink_vend_if.slave  bus
);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CREDIT_W:0] PRICE_W  = (CREDIT_W+1)'(PRICE_HALVES);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                disp_req_q, disp_req_d;
    logic                chg_req_q, chg_req_d;
    logic                coin_rej_q, coin_rej_d;
    logic                busy_q, busy_d;
    logic [CREDIT_W:0]   coin_inc;
    logic [CREDIT_W:0]   cn;

    always_comb begin
        coin_inc   = bus.coin_valid ? (bus.coin_one ? (CREDIT_W+1)'(2) : (CREDIT_W+1)'(1))
                                    : '0;
        cn         = {1'b0, credit_q} + coin_inc;
        state_d    = state_q;
        credit_d   = credit_q;
        tmo_d      = '0;
        coin_rej_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.coin_valid) begin
                    if (cn >= PRICE_W) begin
                        state_d  = DISPENSE;
                        credit_d = CREDIT_W'(cn - PRICE_W);
                    end else begin
                        state_d  = COLLECT;
                        credit_d = CREDIT_W'(cn);
                    end
                end
            end
            COLLECT: begin
                // Reaching the price wins over a simultaneous cancel; a coin arriving
                // with cancel is folded into the refund.
                if (cn >= PRICE_W) begin
                    state_d  = DISPENSE;
                    credit_d = CREDIT_W'(cn - PRICE_W);
                end else if (bus.cancel) begin
                    state_d  = CHANGE;
                    credit_d = CREDIT_W'(cn);
                end else if (bus.coin_valid) begin
                    credit_d = CREDIT_W'(cn);
                end else if (tmo_q == TMO_LAST) begin
                    state_d = CHANGE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DISPENSE: begin
                coin_rej_d = bus.coin_valid;
                if (bus.disp_ack) begin
                    state_d = (credit_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                coin_rej_d = bus.coin_valid;
                if (chg_req_q && bus.chg_ack) begin
                    credit_d = credit_q - 1'b1;
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        disp_req_d = (state_d == DISPENSE);
        chg_req_d  = (state_d == CHANGE) && (credit_d != '0);
        busy_d     = (state_d == DISPENSE) || (state_d == CHANGE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            tmo_q      <= '0;
            disp_req_q <= 1'b0;
            chg_req_q  <= 1'b0;
            coin_rej_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            tmo_q      <= tmo_d;
            disp_req_q <= disp_req_d;
            chg_req_q  <= chg_req_d;
            coin_rej_q <= coin_rej_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.disp_req = disp_req_q;
    assign bus.chg_req  = chg_req_q;
    assign bus.coin_rej = coin_rej_q;
    assign bus.busy     = busy_q;
    assign bus.credit   = credit_q;
endmodule

// File: tb/tb_drink_vend_ctrl.sv
// Scoreboard bench: stimulus queues each expected output change (with its cycle),
// a monitor pops and compares whenever the DUT outputs change.
module tb_drink_vend_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        int         cyc;
        logic [7:0] outs;
    } exp_t;

    exp_t q[$];

    drink_vend_if #(.CREDIT_W(4)) bus ();

    drink_vend_ctrl #(
        .PRICE_HALVES(5),
        .CREDIT_W    (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sample();
        return {bus.disp_req, bus.chg_req, bus.coin_rej, bus.busy, bus.credit};
    endfunction

    // dc < 0: cycle not checked; otherwise change expected when cyc == now + dc
    task automatic expect_out(input int dc, input logic d, input logic c, input logic r,
                              input logic b, input logic [3:0] cr);
        exp_t e;
        e.cyc  = (dc < 0) ? -1 : cyc + dc;
        e.outs = {d, c, r, b, cr};
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one-cycle pulse on the selected inputs, driven from a falling edge
    task automatic pulse(input logic cv, input logic one, input logic can,
                         input logic da, input logic ca);
        bus.coin_valid = cv;
        bus.coin_one   = one;
        bus.cancel     = can;
        bus.disp_ack   = da;
        bus.chg_ack    = ca;
        @(negedge clk);
        bus.coin_valid = 1'b0;
        bus.coin_one   = 1'b0;
        bus.cancel     = 1'b0;
        bus.disp_ack   = 1'b0;
        bus.chg_ack    = 1'b0;
    endtask

    task automatic judge(input logic [7:0] got);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, got);
        end else begin
            e = q.pop_front();
            if (got !== e.outs || (e.cyc >= 0 && cyc != e.cyc)) begin
                errors++;
                $display("FAIL txn%0d outputs got=%h at cyc %0d, required=%h at cyc %0d",
                         checks, got, cyc, e.outs, e.cyc);
            end else begin
                $display("txn%0d cyc=%0d disp=%b chg=%b rej=%b busy=%b credit=%0d ok",
                         checks, cyc, got[7], got[6], got[5], got[4], got[3:0]);
            end
        end
    endtask

    initial begin : monitor
        logic [7:0] prev;
        logic [7:0] cur;
        @(negedge clk);
        #1;
        prev = sample();
        judge(prev);
        forever begin
            @(negedge clk or negedge reset);
            #1;
            cur = sample();
            if (cur !== prev) begin
                judge(cur);
                prev = cur;
            end
        end
    end

    task automatic refund3();
        for (int k = 2; k >= 0; k--) begin
            expect_out(1, 1'b0, k != 0, 1'b0, k != 0, 4'(k));
            pulse(0, 0, 0, 0, 1);
            step(1);
        end
    endtask

    initial begin : stim
        reset          = 1'b0;
        bus.coin_valid = 1'b0;
        bus.coin_one   = 1'b0;
        bus.cancel     = 1'b0;
        bus.disp_ack   = 1'b0;
        bus.chg_ack    = 1'b0;
        expect_out(-1, 0, 0, 0, 0, 4'd0);
        step(2);
        reset = 1'b1;
        step(2);

        // cancel while idle does nothing
        pulse(0, 0, 1, 0, 0);
        step(2);

        // five half coins, then dispense with no change
        for (int i = 1; i <= 4; i++) begin
            expect_out(1, 0, 0, 0, 0, 4'(i));
            pulse(1, 0, 0, 0, 0);
            step(2);
        end
        expect_out(1, 1, 0, 0, 1, 4'd0);
        pulse(1, 0, 0, 0, 0);
        step(3);
        expect_out(1, 0, 0, 0, 0, 4'd0);
        pulse(0, 0, 0, 1, 0);
        step(2);

        // three one-unit coins, one half-coin of change
        expect_out(1, 0, 0, 0, 0, 4'd2); pulse(1, 1, 0, 0, 0); step(2);
        expect_out(1, 0, 0, 0, 0, 4'd4); pulse(1, 1, 0, 0, 0); step(2);
        expect_out(1, 1, 0, 0, 1, 4'd1); pulse(1, 1, 0, 0, 0); step(2);
        expect_out(1, 0, 1, 0, 1, 4'd1); pulse(0, 0, 0, 1, 0); step(2);
        expect_out(1, 0, 0, 0, 0, 4'd0); pulse(0, 0, 0, 0, 1); step(2);

        // one + half, cancel, three-coin refund
        expect_out(1, 0, 0, 0, 0, 4'd2); pulse(1, 1, 0, 0, 0); step(1);
        expect_out(1, 0, 0, 0, 0, 4'd3); pulse(1, 0, 0, 0, 0); step(1);
        expect_out(1, 0, 1, 0, 1, 4'd3); pulse(0, 0, 1, 0, 0); step(2);
        refund3();
        step(1);

        // inactivity timeout: chg_req on the 9th cycle after the coin
        expect_out(1, 0, 0, 0, 0, 4'd2);
        expect_out(9, 0, 1, 0, 1, 4'd2);
        pulse(1, 1, 0, 0, 0);
        step(12);
        expect_out(1, 0, 1, 0, 1, 4'd1); pulse(0, 0, 0, 0, 1); step(1);
        expect_out(1, 0, 0, 0, 0, 4'd0); pulse(0, 0, 0, 0, 1); step(2);

        // disp_ack while idle does nothing
        pulse(0, 0, 0, 1, 0);
        step(2);

        // coin rejected during dispense, then reset mid-dispense
        expect_out(1, 0, 0, 0, 0, 4'd2); pulse(1, 1, 0, 0, 0); step(1);
        expect_out(1, 0, 0, 0, 0, 4'd4); pulse(1, 1, 0, 0, 0); step(1);
        expect_out(1, 1, 0, 0, 1, 4'd1); pulse(1, 1, 0, 0, 0); step(2);
        expect_out(1, 1, 0, 1, 1, 4'd1);
        expect_out(2, 1, 0, 0, 1, 4'd1);
        pulse(1, 0, 0, 0, 0);
        step(3);
        @(posedge clk);
        #2;
        expect_out(0, 0, 0, 0, 0, 4'd0);
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        step(2);

        // price reached together with cancel: dispense, no refund
        expect_out(1, 0, 0, 0, 0, 4'd2); pulse(1, 1, 0, 0, 0); step(1);
        expect_out(1, 0, 0, 0, 0, 4'd4); pulse(1, 1, 0, 0, 0); step(1);
        expect_out(1, 1, 0, 0, 1, 4'd0); pulse(1, 0, 1, 0, 0); step(2);
        expect_out(1, 0, 0, 0, 0, 4'd0); pulse(0, 0, 0, 1, 0); step(2);

        // coin together with cancel below price: coin joins the refund
        expect_out(1, 0, 0, 0, 0, 4'd2); pulse(1, 1, 0, 0, 0); step(1);
        expect_out(1, 0, 1, 0, 1, 4'd3); pulse(1, 0, 1, 0, 0); step(2);
        refund3();
        step(3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_changes got=%0d pending, required=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
